// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD streamer and its add-3 cells.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      EMIT    = 2'd2
   } state_t;

   localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;

   // Smallest digit count d with 10^d > 2^width - 1.
   function automatic int unsigned min_digits(input int unsigned width);
      longint unsigned max_val;
      longint unsigned pow;
      int unsigned     d;
      max_val = (64'd1 << width) - 64'd1;
      pow     = 64'd1;
      d       = 0;
      for (int i = 0; i < 20; i++) begin
         if (pow <= max_val) begin
            pow = pow * 64'd10;
            d++;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bin_to_bcd_streamer_if.sv
// Binary input handshake and BCD digit stream between producer, converter and character stage.
interface bin_to_bcd_streamer_if
   import bcd_pkg::*;
#(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] bin_in;
   logic             digit_valid;
   logic             digit_ready;
   bcd_digit_t       digit_out;
   logic             digit_last;
   logic             busy;

   modport slave (
      input  in_valid, bin_in, digit_ready,
      output in_ready, digit_valid, digit_out, digit_last, busy
   );

   modport master (
      output in_valid, bin_in, digit_ready,
      input  in_ready, digit_valid, digit_out, digit_last, busy
   );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_add3
   import bcd_pkg::*;
(
   input  bcd_digit_t i_digit,
   output bcd_digit_t o_digit
);
   assign o_digit = (i_digit >= BCD_ADD3_THRESH) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bin_to_bcd_streamer.sv
// Iterative double-dabble converter that streams the decimal digits MSD first,
// one BCD digit per handshake.
module bin_to_bcd_streamer
   import bcd_pkg::*;
#(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned DIGITS         = 5,
   parameter bit          SUPPRESS_ZEROS = 1'b0
)(
   input logic                  clk,
   input logic                  rst,
   bin_to_bcd_streamer_if.slave bus
);
   localparam int unsigned BCD_W = DIGITS * 4;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (WIDTH < 4 || WIDTH > 32) begin : g_chk_width
      $error("bin_to_bcd_streamer: WIDTH must be within 4..32");
   end
   if (DIGITS < min_digits(WIDTH)) begin : g_chk_digits
      $error("bin_to_bcd_streamer: DIGITS too small to hold 2^WIDTH-1");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_bin;
   logic [BCD_W-1:0] r_bcd;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic             r_in_ready;
   logic             r_busy;
   logic             r_digit_valid;
   logic             r_digit_last;
   bcd_digit_t       r_digit_out;

   logic [BCD_W-1:0] w_bcd_adj;
   logic [BCD_W-1:0] w_bcd_shift;
   logic [IDX_W-1:0] w_start_idx;
   logic [IDX_W-1:0] w_idx_dec;
   bcd_digit_t       w_start_digit;
   bcd_digit_t       w_next_digit;
   logic             w_unused_msb;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .i_digit (r_bcd[4*g +: 4]),
         .o_digit (w_bcd_adj[4*g +: 4])
      );
   end

   // The corrected top bit is always shifted out as zero for a legal DIGITS.
   assign w_bcd_shift  = {w_bcd_adj[BCD_W-2:0], r_bin[WIDTH-1]};
   assign w_unused_msb = w_bcd_adj[BCD_W-1];
   assign w_idx_dec    = r_idx - IDX_W'(1);

   // First digit to emit, chosen from the value the final shift produces.
   always_comb begin
      w_start_idx   = IDX_W'(DIGITS - 1);
      w_start_digit = '0;
      w_next_digit  = '0;
      if (SUPPRESS_ZEROS) begin
         w_start_idx = '0;
         for (int d = 0; d < DIGITS; d++) begin
            if (w_bcd_shift[4*d +: 4] != 4'd0) w_start_idx = IDX_W'(d);
         end
      end
      for (int d = 0; d < DIGITS; d++) begin
         if (IDX_W'(d) == w_start_idx) w_start_digit = w_bcd_shift[4*d +: 4];
         if (IDX_W'(d) == w_idx_dec)   w_next_digit  = r_bcd[4*d +: 4];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_bin         <= '0;
         r_bcd         <= '0;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_in_ready    <= 1'b1;
         r_busy        <= 1'b0;
         r_digit_valid <= 1'b0;
         r_digit_last  <= 1'b0;
         r_digit_out   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_bin      <= bus.bin_in;
                  r_bcd      <= '0;
                  r_cnt      <= CNT_W'(WIDTH);
                  r_state    <= CONVERT;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            CONVERT: begin
               r_bcd <= w_bcd_shift;
               r_bin <= {r_bin[WIDTH-2:0], 1'b0};
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state       <= EMIT;
                  r_idx         <= w_start_idx;
                  r_digit_out   <= w_start_digit;
                  r_digit_last  <= (w_start_idx == '0);
                  r_digit_valid <= 1'b1;
               end
            end
            EMIT: begin
               if (bus.digit_ready) begin
                  if (r_idx == '0) begin
                     r_state       <= IDLE;
                     r_in_ready    <= 1'b1;
                     r_busy        <= 1'b0;
                     r_digit_valid <= 1'b0;
                     r_digit_last  <= 1'b0;
                     r_digit_out   <= '0;
                  end else begin
                     r_idx        <= w_idx_dec;
                     r_digit_out  <= w_next_digit;
                     r_digit_last <= (w_idx_dec == '0);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.busy        = r_busy;
   assign bus.digit_valid = r_digit_valid;
   assign bus.digit_out   = r_digit_out;
   assign bus.digit_last  = r_digit_last;

endmodule

// File: tb/tb_bin_to_bcd_streamer.sv
// Directed bench for bin_to_bcd_streamer: one default instance and one with leading-zero suppression.
module tb_bin_to_bcd_streamer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        iv  = 1'b0;
   logic        dr  = 1'b1;
   logic [15:0] bin = '0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   bin_to_bcd_streamer_if #(.WIDTH(16)) if_a ();
   bin_to_bcd_streamer_if #(.WIDTH(16)) if_z ();

   assign if_a.in_valid    = iv & ~sel;
   assign if_z.in_valid    = iv & sel;
   assign if_a.bin_in      = bin;
   assign if_z.bin_in      = bin;
   assign if_a.digit_ready = dr;
   assign if_z.digit_ready = dr;

   wire       m_ir   = sel ? if_z.in_ready    : if_a.in_ready;
   wire       m_dv   = sel ? if_z.digit_valid : if_a.digit_valid;
   wire       m_last = sel ? if_z.digit_last  : if_a.digit_last;
   wire       m_busy = sel ? if_z.busy        : if_a.busy;
   wire [3:0] m_dig  = sel ? if_z.digit_out   : if_a.digit_out;

   bin_to_bcd_streamer #(.WIDTH(16), .DIGITS(5), .SUPPRESS_ZEROS(1'b0)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a)
   );

   bin_to_bcd_streamer #(.WIDTH(16), .DIGITS(5), .SUPPRESS_ZEROS(1'b1)) u_dut_z (
      .clk (clk),
      .rst (rst),
      .bus (if_z)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Accept v from an idle DUT, then collect n digits MSD first under a ready pattern.
   task automatic run_value(input logic [15:0] v, input logic [19:0] exp_bcd, input int n,
                            input logic [15:0] pat, input int plen);
      int cyc;
      int k;
      int p;
      iv  = 1'b1;
      bin = v;
      dr  = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      check("busy_after_accept", 32'(m_busy), 1);
      check("in_ready_after_accept", 32'(m_ir), 0);
      cyc = 1;
      while (!m_dv && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("latency", cyc, 17);
      k = 0;
      p = 0;
      while (k < n && p < 200) begin
         dr = (p < plen) ? pat[p] : 1'b1;
         check("digit_valid", 32'(m_dv), 1);
         check("digit", 32'(m_dig), 32'(exp_bcd[4*(n-1-k) +: 4]));
         check("digit_last", 32'(m_last), 32'(k == n - 1));
         if (dr) k++;
         p++;
         @(negedge clk);
      end
      check("digit_count", k, n);
      check("digit_valid_after", 32'(m_dv), 0);
      check("in_ready_after", 32'(m_ir), 1);
      dr = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] got[$];
      logic [3:0] exp_bb [10] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd2, 4'd2, 4'd2};
      int acc;
      int lastn;
      int a2;
      int l1;
      int cyc;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(if_a.in_ready), 1);
      check("rst_busy", 32'(if_a.busy), 0);
      check("rst_digit_valid", 32'(if_a.digit_valid), 0);
      check("rst_digit_out", 32'(if_a.digit_out), 0);
      check("rst_digit_last", 32'(if_a.digit_last), 0);
      check("rst_z_in_ready", 32'(if_z.in_ready), 1);
      check("rst_z_busy", 32'(if_z.busy), 0);
      rst = 1'b0;
      @(negedge clk);

      // Default instance, full-rate and stalled.
      sel = 1'b0;
      run_value(16'd12345, 20'h12345, 5, 16'h0, 0);
      run_value(16'd65535, 20'h65535, 5, 16'h0, 0);
      run_value(16'd9,     20'h00009, 5, 16'h0, 0);
      run_value(16'd12345, 20'h12345, 5, 16'b0000_0001_1011_0100, 9);

      // Leading-zero suppression.
      sel = 1'b1;
      run_value(16'd0,     20'h00000, 1, 16'h0, 0);
      run_value(16'd407,   20'h00407, 3, 16'h0, 0);
      run_value(16'd10000, 20'h10000, 5, 16'h0, 0);

      // Back-to-back with in_valid held high.
      sel   = 1'b0;
      iv    = 1'b1;
      bin   = 16'd111;
      dr    = 1'b1;
      acc   = 0;
      lastn = 0;
      a2    = -1;
      l1    = -1;
      cyc   = 0;
      while (lastn < 2 && cyc < 200) begin
         if (m_busy) check("in_ready_while_busy", 32'(m_ir), 0);
         if (iv && m_ir) begin
            acc++;
            if (acc == 2) a2 = cyc;
         end
         if (m_dv && dr) begin
            got.push_back(m_dig);
            if (m_last) begin
               lastn++;
               if (lastn == 1) l1 = cyc;
            end
         end
         cyc++;
         @(negedge clk);
         if (acc == 1) bin = 16'd222;
      end
      iv = 1'b0;
      check("bb_second_accept_gap", a2 - l1, 1);
      @(negedge clk);
      check("bb_no_third_accept", 32'(m_busy), 0);
      check("bb_accept_count", acc, 2);
      check("bb_digit_count", got.size(), 10);
      for (int i = 0; i < 10; i++) begin
         check("bb_digit", 32'((i < got.size()) ? got[i] : 4'hF), 32'(exp_bb[i]));
      end

      // Reset in the middle of emitting 54321.
      iv  = 1'b1;
      bin = 16'd54321;
      @(negedge clk);
      iv  = 1'b0;
      cyc = 1;
      while (!m_dv && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("mid_latency", cyc, 17);
      check("mid_digit0", 32'(m_dig), 5);
      @(negedge clk);
      check("mid_digit1", 32'(m_dig), 4);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_digit_valid", 32'(m_dv), 0);
      check("mid_rst_busy", 32'(m_busy), 0);
      check("mid_rst_in_ready", 32'(m_ir), 1);
      run_value(16'd7, 20'h00007, 5, 16'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
